// File: rtl/mem_lsu_if.sv
// Bundle for the load/store unit: CPU request/response handshake plus the memory data port.
// The slave modport is the LSU's view; the master modport is the core/memory environment.
interface mem_lsu_if #(
    parameter int ADDR_W = 10
) ();
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [1:0]        req_size_i;
    logic              req_unsigned_i;
    logic [31:0]       req_addr_i;
    logic [31:0]       req_wdata_i;
    logic              rsp_valid_o;
    logic              rsp_err_o;
    logic [31:0]       rsp_rdata_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_we_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        input  mem_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o,
        output mem_addr_o, mem_we_o, mem_wdata_o
    );

    modport master (
        output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        output mem_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o,
        input  mem_addr_o, mem_we_o, mem_wdata_o
    );
endinterface

// File: rtl/mem_lsu.sv
// Load/store unit: byte-addressed byte/half/word CPU accesses onto a word-only memory port.
// Sub-word stores are done as read-modify-write; loads are lane-extracted and extended.
module mem_lsu #(
    parameter int ADDR_W = 10
) (
    input  logic      clk,
    input  logic      rst_n,
    mem_lsu_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        lane_q, lane_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    // Address bits above the memory size are deliberately dropped (addresses wrap).
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr_i[31:ADDR_W+2];

    logic acc_err;
    assign acc_err = (bus.req_size_i == SZ_X)
                   || ((bus.req_size_i == SZ_H) && bus.req_addr_i[0])
                   || ((bus.req_size_i == SZ_W) && (bus.req_addr_i[1:0] != 2'b00));

    // Store data replicated into every lane so each byte lane only needs a select.
    logic [31:0] st_rep;
    logic [3:0]  byte_en;
    logic [31:0] merged;
    assign st_rep = (size_q == SZ_B) ? {4{wdata_q[7:0]}} : {2{wdata_q}};

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        assign byte_en[gi] = (size_q == SZ_B) ? (lane_q == LANE) : (lane_q[1] == LANE[1]);
        assign merged[gi*8 +: 8] = byte_en[gi] ? st_rep[gi*8 +: 8] : bus.mem_rdata_i[gi*8 +: 8];
    end

    logic [31:0] shifted;
    logic [31:0] ld_ext;
    assign shifted = bus.mem_rdata_i >> {lane_q, 3'b000};

    always_comb begin
        ld_ext = shifted;
        case (size_q)
            SZ_B:    ld_ext = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            SZ_H:    ld_ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            default: ld_ext = shifted;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        lane_d      = lane_q;
        wdata_d     = wdata_q;
        ready_d     = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'd0;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = 32'd0;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (bus.req_valid_i && ready_q) begin
                    ready_d = 1'b0;
                    we_d    = bus.req_we_i;
                    size_d  = bus.req_size_i;
                    uns_d   = bus.req_unsigned_i;
                    lane_d  = bus.req_addr_i[1:0];
                    wdata_d = bus.req_wdata_i[15:0];
                    if (acc_err) begin
                        state_d     = RSP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        mem_addr_d = bus.req_addr_i[ADDR_W+1:2];
                        if (bus.req_we_i && (bus.req_size_i == SZ_W)) begin
                            state_d     = WR;
                            mem_we_d    = 1'b1;
                            mem_wdata_d = bus.req_wdata_i;
                        end else begin
                            state_d = RD;
                        end
                    end
                end
            end
            RD: begin
                if (we_q) begin
                    state_d     = WR;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = merged;
                end else begin
                    state_d     = RSP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = ld_ext;
                end
            end
            WR: begin
                state_d     = RSP;
                rsp_valid_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            lane_q      <= 2'b00;
            wdata_q     <= 16'd0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            lane_q      <= lane_d;
            wdata_q     <= wdata_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.req_ready_o = ready_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_wdata_o = mem_wdata_q;
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: word-addressed memory model, per-request latency and write tracking.
module tb_mem_lsu;
    localparam int ADDR_W = 10;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   wr_count;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    mem_lsu_if #(.ADDR_W(ADDR_W)) bus ();

    mem_lsu #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata_i = mem[bus.mem_addr_o];

    always @(posedge clk) begin
        if (bus.mem_we_o) begin
            mem[bus.mem_addr_o] <= bus.mem_wdata_o;
            wr_count <= wr_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Issues one request; latency/write cycles are counted from the accept cycle T.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic err,
                          output int nwr, output int wr_at);
        int n;
        @(negedge clk);
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = we;
        bus.req_size_i     = size;
        bus.req_unsigned_i = uns;
        bus.req_addr_i     = addr;
        bus.req_wdata_i    = wd;
        n = 0;
        while (!bus.req_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
        lat = -1; rd = 32'hxxxxxxxx; err = 1'bx; nwr = 0; wr_at = -1;
        for (int k = 1; k <= 10 && lat < 0; k++) begin
            @(negedge clk);
            if (bus.mem_we_o) begin
                nwr++;
                wr_at = k;
            end
            if (bus.rsp_valid_o) begin
                lat = k;
                rd  = bus.rsp_rdata_o;
                err = bus.rsp_err_o;
            end
        end
        $display("txn we=%0b size=%0d uns=%0b addr=0x%08h wdata=0x%08h lat=%0d rdata=0x%08h err=%0b writes=%0d",
                 we, size, uns, addr, wd, lat, rd, err, nwr);
    endtask

    int          lat, nwr, wr_at, wc0;
    logic [31:0] rd;
    logic        err;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        wr_count = 0;
        rst_n    = 1'b0;
        bus.req_valid_i    = 1'b0;
        bus.req_we_i       = 1'b0;
        bus.req_size_i     = 2'b00;
        bus.req_unsigned_i = 1'b0;
        bus.req_addr_i     = 32'd0;
        bus.req_wdata_i    = 32'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready",     32'(bus.req_ready_o), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("rst_rdata",     bus.rsp_rdata_o,      32'd0);
        check("rst_mem_we",    32'(bus.mem_we_o),    32'd0);
        check("rst_mem_addr",  32'(bus.mem_addr_o),  32'd0);

        // 1: word store then word load
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, err, nwr, wr_at);
        check("t1_st_lat",   32'(lat),   32'd2);
        check("t1_st_err",   32'(err),   32'd0);
        check("t1_st_rdata", rd,         32'd0);
        check("t1_st_wrat",  32'(wr_at), 32'd1);
        check("t1_mem4",     mem[4],     32'hDEADBEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, err, nwr, wr_at);
        check("t1_ld_lat",   32'(lat),   32'd2);
        check("t1_ld_data",  rd,         32'hDEADBEEF);
        check("t1_ld_nwr",   32'(nwr),   32'd0);

        // 2: byte store RMW
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, lat, rd, err, nwr, wr_at);
        do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA, lat, rd, err, nwr, wr_at);
        check("t2_lat",   32'(lat),   32'd3);
        check("t2_nwr",   32'(nwr),   32'd1);
        check("t2_wrat",  32'(wr_at), 32'd2);
        check("t2_mem4",  mem[4],     32'h11AA3344);
        do_req(1'b1, 2'b01, 1'b0, 32'h10, 32'h0000BEEF, lat, rd, err, nwr, wr_at);
        check("t2_half_mem4", mem[4], 32'h11AABEEF);

        // 3: lane extraction and extension
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01, lat, rd, err, nwr, wr_at);
        do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, lat, rd, err, nwr, wr_at);
        check("t3_lb_11",  rd, 32'h0000007F);
        do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, rd, err, nwr, wr_at);
        check("t3_lh_12",  rd, 32'hFFFF80FF);
        do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, rd, err, nwr, wr_at);
        check("t3_lhu_12", rd, 32'h000080FF);
        do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, rd, err, nwr, wr_at);
        check("t3_lb_13",  rd, 32'hFFFFFF80);
        do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, lat, rd, err, nwr, wr_at);
        check("t3_lbu_13", rd, 32'h00000080);

        // 4: error cases
        do_req(1'b1, 2'b01, 1'b0, 32'h13, 32'h5555, lat, rd, err, nwr, wr_at);
        check("t4_h13_lat", 32'(lat), 32'd1);
        check("t4_h13_err", 32'(err), 32'd1);
        check("t4_h13_nwr", 32'(nwr), 32'd0);
        do_req(1'b1, 2'b10, 1'b0, 32'h06, 32'h12345678, lat, rd, err, nwr, wr_at);
        check("t4_w06_err", 32'(err), 32'd1);
        check("t4_w06_nwr", 32'(nwr), 32'd0);
        do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, lat, rd, err, nwr, wr_at);
        check("t4_sz3_lat",   32'(lat), 32'd1);
        check("t4_sz3_err",   32'(err), 32'd1);
        check("t4_sz3_rdata", rd,       32'd0);
        check("t4_mem4",      mem[4],   32'h80FF7F01);

        // 5: reset during the write cycle of a byte RMW
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, lat, rd, err, nwr, wr_at);
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = 1'b1;
        bus.req_size_i  = 2'b00;
        bus.req_addr_i  = 32'h12;
        bus.req_wdata_i = 32'hAA;
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
        for (int k = 0; k < 5 && !bus.mem_we_o; k++) @(negedge clk);
        check("t5_in_wr", 32'(bus.mem_we_o), 32'd1);
        wc0 = wr_count;
        #1 rst_n = 1'b0;
        #1;
        check("t5_we_async",    32'(bus.mem_we_o),    32'd0);
        check("t5_ready_async", 32'(bus.req_ready_o), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_no_write", 32'(wr_count - wc0), 32'd0);
        check("t5_mem4",     mem[4],              32'h11223344);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, err, nwr, wr_at);
        check("t5_after_lat",  32'(lat), 32'd2);
        check("t5_after_data", rd,       32'h11223344);

        // 6: valid held high for three wrapped word loads
        begin
            int acc_cyc[3];
            int rsp_cyc[3];
            logic [31:0] rsp_dat[3];
            int na, nr;
            na = 0; nr = 0;
            @(negedge clk);
            bus.req_valid_i = 1'b1;
            bus.req_we_i    = 1'b0;
            bus.req_size_i  = 2'b10;
            bus.req_addr_i  = 32'h1010;
            for (int c = 0; c < 14; c++) begin
                if (c > 0) @(negedge clk);
                if (bus.rsp_valid_o && nr < 3) begin
                    rsp_cyc[nr] = c;
                    rsp_dat[nr] = bus.rsp_rdata_o;
                    $display("txn b2b rsp at cycle %0d rdata=0x%08h", c, bus.rsp_rdata_o);
                    nr++;
                end
                if (bus.req_ready_o) begin
                    if (na < 3) begin
                        acc_cyc[na] = c;
                        na++;
                    end else begin
                        bus.req_valid_i = 1'b0;
                    end
                end
            end
            bus.req_valid_i = 1'b0;
            check("t6_n_acc", 32'(na), 32'd3);
            check("t6_n_rsp", 32'(nr), 32'd3);
            for (int i = 0; i < 3; i++) begin
                if (i < na) check($sformatf("t6_acc%0d", i), 32'(acc_cyc[i]), 32'(3*i));
                if (i < nr) begin
                    check($sformatf("t6_rsp%0d", i),  32'(rsp_cyc[i]), 32'(3*i + 2));
                    check($sformatf("t6_data%0d", i), rsp_dat[i],      32'h11223344);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
